sim_run_monitor: RTL and testbench
==================================

SIM_RUN_MONITOR -- requirements
Module: sim_run_monitor

Interface
REQ-001 Parameter XLEN, 32, register/PC width.
REQ-002 Parameter NREGS, 32, architectural registers dumped (2..64).
REQ-003 Parameter TIMEOUT_CYCLES, 250, RUN cycles before forced stop; 0 disables timeout.
REQ-004 Parameter HALT_INSTR, 32'h00100073, M-stage encoding that signals halt.
REQ-005 Parameter DRAIN_CYCLES, 2, post-stop cycles before freeze (1..255).
REQ-006 Parameter CNT_W, 32, counter width.
REQ-007 Ports: clk in 1, clock; rst in 1, reset (asynchronous, active-high).
REQ-008 Ports: en in 1, start request; instr_m in 32, M-stage instruction; instr_valid_m in 1, M-stage instruction retires this cycle; pc_f in XLEN, fetch PC.
REQ-009 Ports: rf_raddr out $clog2(NREGS), register-file read index; rf_rdata in XLEN, combinational read data.
REQ-010 Ports: dump_valid out 1; dump_ready in 1; dump_idx out $clog2(NREGS+1); dump_data out XLEN; dump handshake.
REQ-011 Ports: freeze out 1, core stall; cycle_count out CNT_W; retired_count out CNT_W; halted out 1; timed_out out 1; done out 1.

Function
REQ-012 FSM states: IDLE, RUN, DRAIN, DUMP, DONE.
REQ-013 IDLE->RUN when en=1; on this transition, cycle_count, retired_count, halted and timed_out clear to 0.
REQ-014 RUN: cycle_count +1 per cycle, saturating at all-ones; retired_count +1 per cycle with instr_valid_m=1, in RUN and DRAIN only.
REQ-015 RUN->DRAIN when instr_valid_m=1 and instr_m==HALT_INSTR; halted set to 1 on the transition.
REQ-016 RUN->DRAIN when TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 (the TIMEOUT_CYCLES-th RUN cycle); timed_out set to 1.
REQ-017 Halt and timeout in the same cycle: halted=1, timed_out=0.
REQ-018 DRAIN: hold for exactly DRAIN_CYCLES cycles; cycle_count frozen; no further halt/timeout evaluation.
REQ-019 DRAIN->DUMP: PC captured from pc_f in the last DRAIN cycle; freeze=1 from the first DUMP cycle until IDLE is re-entered.
REQ-020 DUMP emits NREGS+1 beats: beat 0 dump_idx=0, dump_data=captured PC; beat k (1..NREGS): dump_idx=k, rf_raddr=k-1, dump_data=rf_rdata.
REQ-021 dump_valid=1 throughout DUMP; beat advances only on dump_valid&&dump_ready; dump_idx/dump_data/rf_raddr stable while dump_ready=0.
REQ-022 Beat NREGS accepted -> DONE; dump_valid=0 in all states but DUMP.
REQ-023 DONE: done=1, freeze=1; all counters and flags held; DONE->IDLE when en=0.
REQ-024 en ignored in RUN, DRAIN and DUMP; a run completes once started.
REQ-025 rf_raddr=0 outside DUMP.

Reset
REQ-026 rst=1 forces IDLE asynchronously, regardless of current state, including mid-DUMP.
REQ-027 Reset values: cycle_count=0, retired_count=0, halted=0, timed_out=0, done=0, freeze=0, dump_valid=0, dump_idx=0, rf_raddr=0, captured PC=0.
REQ-028 First clock edge after rst falls may leave IDLE if en=1.

Verification
REQ-029 Halt: en=1; 10 retires, then instr_m=32'h00100073 valid on RUN cycle 20 -> halted=1, timed_out=0, cycle_count=20, retired_count=11 plus DRAIN retires; DUMP after 2 DRAIN cycles.
REQ-030 Timeout: no halt, TIMEOUT_CYCLES=250 -> DRAIN entered after RUN cycle 250, cycle_count=250, timed_out=1, halted=0.
REQ-031 Simultaneous: halt on RUN cycle 250 with TIMEOUT_CYCLES=250 -> halted=1, timed_out=0.
REQ-032 Dump backpressure: dump_ready toggled randomly, rf pre-loaded xi=i*3, pc_f=0x100 in last DRAIN cycle -> 33 beats in order; idx0=0x100, idx k=3(k-1); data stable while ready=0.
REQ-033 Reset mid-DUMP at beat 5 -> next cycle: dump_valid=0, freeze=0, done=0, state IDLE; a new run with en=1 restarts with counters at 0.
REQ-034 DONE hold: en held 1 after DONE -> remains DONE; en=0 -> IDLE next cycle, freeze=0.

Source files
------------

// File: rtl/sim_run_monitor.sv
// Simulation run monitor: starts a run on en, counts cycles and retires, stops on
// halt or timeout, drains the pipe, then streams PC and register file out under freeze.
module sim_run_monitor #(
    parameter int          XLEN           = 32,
    parameter int          NREGS          = 32,
    parameter int          TIMEOUT_CYCLES = 250,
    parameter logic [31:0] HALT_INSTR     = 32'h00100073,
    parameter int          DRAIN_CYCLES   = 2,
    parameter int          CNT_W          = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [31:0]                instr_m,
    input  logic                       instr_valid_m,
    input  logic [XLEN-1:0]            pc_f,
    output logic [$clog2(NREGS)-1:0]   rf_raddr,
    input  logic [XLEN-1:0]            rf_rdata,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [$clog2(NREGS+1)-1:0] dump_idx,
    output logic [XLEN-1:0]            dump_data,
    output logic                       freeze,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           retired_count,
    output logic                       halted,
    output logic                       timed_out,
    output logic                       done
);
    localparam int AW = $clog2(NREGS);
    localparam int IW = $clog2(NREGS + 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0]    LAST_BEAT  = IW'(NREGS);
    localparam logic [7:0]       DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cycle_q, cycle_d, ret_q, ret_d;
    logic             halted_q, halted_d, to_q, to_d;
    logic [7:0]       drain_q, drain_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    raddr_q, raddr_d;
    logic             dump_valid_q, dump_valid_d, freeze_q, freeze_d, done_q, done_d;
    logic             halt_hit, to_hit;

    always_comb begin
        state_d  = state_q;
        cycle_d  = cycle_q;
        ret_d    = ret_q;
        halted_d = halted_q;
        to_d     = to_q;
        drain_d  = drain_q;
        pc_d     = pc_q;
        idx_d    = idx_q;
        halt_hit = instr_valid_m && (instr_m == HALT_INSTR);
        to_hit   = (TIMEOUT_CYCLES != 0) && (cycle_q == TO_LAST);

        if ((state_q == S_RUN || state_q == S_DRAIN) && instr_valid_m)
            ret_d = ret_q + 1'b1;

        case (state_q)
            S_IDLE: if (en) begin
                state_d  = S_RUN;
                cycle_d  = '0;
                ret_d    = '0;
                halted_d = 1'b0;
                to_d     = 1'b0;
                idx_d    = '0;
            end
            S_RUN: begin
                if (cycle_q != '1)
                    cycle_d = cycle_q + 1'b1;
                // a halt retiring on the timeout cycle is reported as a halt
                if (halt_hit || to_hit) begin
                    state_d  = S_DRAIN;
                    drain_d  = '0;
                    halted_d = halt_hit;
                    to_d     = !halt_hit;
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 8'd1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_DUMP;
                    pc_d    = pc_f;
                    idx_d   = '0;
                end
            end
            S_DUMP: if (dump_ready) begin
                if (idx_q == LAST_BEAT) state_d = S_DONE;
                else                    idx_d   = idx_q + 1'b1;
            end
            S_DONE: if (!en) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        dump_valid_d = (state_d == S_DUMP);
        freeze_d     = (state_d == S_DUMP) || (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
        // beat k reads register k-1; beat 0 is the captured PC
        raddr_d      = (state_d == S_DUMP && idx_d != '0) ? AW'(idx_d - 1'b1) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cycle_q      <= '0;
            ret_q        <= '0;
            halted_q     <= 1'b0;
            to_q         <= 1'b0;
            drain_q      <= '0;
            pc_q         <= '0;
            idx_q        <= '0;
            raddr_q      <= '0;
            dump_valid_q <= 1'b0;
            freeze_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cycle_q      <= cycle_d;
            ret_q        <= ret_d;
            halted_q     <= halted_d;
            to_q         <= to_d;
            drain_q      <= drain_d;
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            raddr_q      <= raddr_d;
            dump_valid_q <= dump_valid_d;
            freeze_q     <= freeze_d;
            done_q       <= done_d;
        end
    end

    assign rf_raddr      = raddr_q;
    assign dump_valid    = dump_valid_q;
    assign dump_idx      = idx_q;
    assign dump_data     = (idx_q == '0) ? pc_q : rf_rdata;
    assign freeze        = freeze_q;
    assign cycle_count   = cycle_q;
    assign retired_count = ret_q;
    assign halted        = halted_q;
    assign timed_out     = to_q;
    assign done          = done_q;
endmodule

// File: tb/tb_sim_run_monitor.sv
// Bench for sim_run_monitor: table-driven runs, reset mid-dump, and randomized runs
// checked against a cycle-by-cycle run model with a combinational register file.
module tb_sim_run_monitor;
    localparam int          NREGS = 32;
    localparam int          XLEN  = 32;
    localparam int          TO    = 250;
    localparam int          DRN   = 2;
    localparam logic [31:0] HALT  = 32'h00100073;

    logic             clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic             instr_valid_m = 1'b0, dump_ready = 1'b0;
    logic [31:0]      instr_m = '0;
    logic [XLEN-1:0]  pc_f = '0, rf_rdata, dump_data;
    logic [4:0]       rf_raddr;
    logic [5:0]       dump_idx;
    logic             dump_valid, freeze, halted, timed_out, done;
    logic [31:0]      cycle_count, retired_count;

    logic [XLEN-1:0]  rf [NREGS];
    bit               vv [1:TO];
    logic [31:0]      ii [1:TO];
    bit               dv [1:DRN];
    int               n_tests = 0, n_fail = 0;

    assign rf_rdata = rf[rf_raddr];
    always #5 clk = ~clk;

    sim_run_monitor dut (
        .clk(clk), .rst(rst), .en(en), .instr_m(instr_m), .instr_valid_m(instr_valid_m),
        .pc_f(pc_f), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .freeze(freeze),
        .cycle_count(cycle_count), .retired_count(retired_count), .halted(halted),
        .timed_out(timed_out), .done(done)
    );

    typedef struct {
        int          halt_at;   // RUN cycle of the halt retire, 0 = none
        int          n_ret;     // retires on RUN cycles 1..n_ret
        int          drain_ret; // retires in the first drain_ret DRAIN cycles
        bit          bp;        // random dump backpressure
        logic [31:0] pc;        // pc_f in last DRAIN cycle
        int          e_cyc;
        int          e_ret;
        bit          e_h;
        bit          e_t;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic build(input int halt_at, input int n_ret, input int drain_ret);
        for (int c = 1; c <= TO; c++) begin
            vv[c] = (c <= n_ret);
            ii[c] = vv[c] ? 32'h00000013 + 32'(c << 7) : HALT;  // halt encoding without valid
        end
        if (halt_at != 0) begin
            vv[halt_at] = 1'b1;
            ii[halt_at] = HALT;
        end
        for (int d = 1; d <= DRN; d++) dv[d] = (d <= drain_ret);
    endtask

    // Reference: walk RUN cycles until the first valid halt or the timeout cycle.
    task automatic model(output int rl, output int cyc, output int ret, output bit h, output bit t);
        rl = TO; ret = 0; h = 1'b0; t = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            ret += int'(vv[c]);
            if (vv[c] && ii[c] == HALT) begin
                h  = 1'b1;
                rl = c;
                break;
            end
        end
        t   = !h;
        cyc = rl;
        for (int d = 1; d <= DRN; d++) ret += int'(dv[d]);
    endtask

    task automatic do_run(input int rl, input bit bp, input logic [31:0] pc, input int e_cyc,
                          input int e_ret, input bit e_h, input bit e_t, input string tag);
        int b, g;
        en = 1'b1;
        instr_valid_m = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".start_cyc"}, cycle_count, 0);
        chk({tag, ".start_ret"}, retired_count, 0);
        chk({tag, ".start_flags"}, {halted, timed_out, freeze, dump_valid, done}, 0);
        for (int c = 1; c <= rl; c++) begin
            instr_valid_m = vv[c];
            instr_m       = ii[c];
            pc_f          = $urandom;
            @(posedge clk); #1;
        end
        for (int d = 1; d <= DRN; d++) begin
            chk({tag, ".drain_vld"}, dump_valid, 0);
            instr_valid_m = dv[d];
            instr_m       = HALT;
            pc_f          = (d == DRN) ? pc : $urandom;
            @(posedge clk); #1;
        end
        instr_valid_m = 1'b0;
        chk({tag, ".dump_entry"}, {dump_valid, freeze, done}, 3'b110);
        chk({tag, ".cyc"}, cycle_count, e_cyc);
        chk({tag, ".ret"}, retired_count, e_ret);
        chk({tag, ".halt_to"}, {halted, timed_out}, {e_h, e_t});
        b = 0; g = 0;
        while (b <= NREGS && g < 1000) begin
            if (!dump_valid) begin
                chk({tag, ".dump_valid_lost"}, dump_valid, 1);
                break;
            end
            chk({tag, ".beat_idx"}, dump_idx, b);
            chk({tag, ".beat_data"}, dump_data, (b == 0) ? pc : rf[b-1]);
            dump_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (dump_ready) b++;
            g++;
        end
        dump_ready = 1'b0;
        chk({tag, ".beats"}, b, NREGS + 1);
        chk({tag, ".done_state"}, {done, freeze, dump_valid, rf_raddr}, {3'b110, 5'd0});
        chk({tag, ".done_cnt"}, {cycle_count, retired_count}, {32'(e_cyc), 32'(e_ret)});
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".done_hold"}, {done, freeze, halted, timed_out}, {2'b11, e_h, e_t});
        chk({tag, ".done_hold_cnt"}, cycle_count, e_cyc);
        en = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".idle_back"}, {done, freeze, dump_valid}, 0);
    endtask

    initial begin
        vec_t tbl [6];
        int   g, rl, cyc, ret;
        bit   h, t;
        logic [31:0] pcx;

        tbl[0] = '{20,  10,  2, 1'b1, 32'h100,  20,  13, 1'b1, 1'b0};
        tbl[1] = '{0,   0,   0, 1'b0, 32'h2000, 250, 0,   1'b0, 1'b1};
        tbl[2] = '{0,   250, 1, 1'b1, 32'hABC,  250, 251, 1'b0, 1'b1};
        tbl[3] = '{250, 100, 0, 1'b0, 32'h44,   250, 101, 1'b1, 1'b0};
        tbl[4] = '{1,   0,   2, 1'b0, 32'h8,    1,   3,   1'b1, 1'b0};
        tbl[5] = '{249, 0,   0, 1'b1, 32'h10,   249, 1,   1'b1, 1'b0};
        for (int i = 0; i < NREGS; i++) rf[i] = 32'(i * 3);

        #12;
        chk("reset.counts", {cycle_count, retired_count}, 0);
        chk("reset.flags", {halted, timed_out, done, freeze, dump_valid}, 0);
        chk("reset.idx", {dump_idx, rf_raddr}, 0);
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            build(tbl[i].halt_at, tbl[i].n_ret, tbl[i].drain_ret);
            do_run((tbl[i].halt_at != 0) ? tbl[i].halt_at : TO, tbl[i].bp, tbl[i].pc,
                   tbl[i].e_cyc, tbl[i].e_ret, tbl[i].e_h, tbl[i].e_t, $sformatf("tbl%0d", i));
        end

        // reset while beat 5 is on the bus
        build(5, 2, 0);
        en = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 5; c++) begin
            instr_valid_m = vv[c];
            instr_m       = ii[c];
            @(posedge clk); #1;
        end
        instr_valid_m = 1'b0;
        en = 1'b0;
        dump_ready = 1'b1;
        g = 0;
        while (dump_idx != 6'd5 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("rstdump.reach5", {dump_valid, dump_idx}, {1'b1, 6'd5});
        chk("rstdump.pre_halted", halted, 1);
        rst = 1'b1;
        #1;
        chk("rstdump.async", {dump_valid, freeze, done, halted}, 0);
        @(posedge clk); #1;
        chk("rstdump.next", {dump_valid, freeze, done, dump_idx}, 0);
        chk("rstdump.cnt", {cycle_count, retired_count}, 0);
        dump_ready = 1'b0;
        @(negedge clk) rst = 1'b0;
        build(tbl[4].halt_at, tbl[4].n_ret, tbl[4].drain_ret);
        do_run(1, 1'b0, 32'h8, 1, 3, 1'b1, 1'b0, "rstdump.rerun");

        for (int r = 0; r < 12; r++) begin
            int hp;
            for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
            for (int c = 1; c <= TO; c++) begin
                vv[c] = 1'($urandom_range(0, 1));
                ii[c] = $urandom;
                if (ii[c] == HALT) ii[c] = ~HALT;
                if (!vv[c] && $urandom_range(0, 3) == 0) ii[c] = HALT;
            end
            hp = $urandom_range(1, 320);
            if (hp <= TO) begin
                vv[hp] = 1'b1;
                ii[hp] = HALT;
            end
            for (int d = 1; d <= DRN; d++) dv[d] = 1'($urandom_range(0, 1));
            pcx = $urandom;
            model(rl, cyc, ret, h, t);
            do_run(rl, 1'b1, pcx, cyc, ret, h, t, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
